// File: rtl/sc_game_status.sv
// sc_game_status: lives/level counters with edge-detected events and a transition timer FSM
module sc_game_status #(
    parameter int INIT_LIVES       = 3,
    parameter int MAX_LEVEL        = 4,
    parameter int TRANSITION_TICKS = 25000000
) (
    input  logic       SC_GAME_STATUS_CLOCK_50,
    input  logic       SC_GAME_STATUS_RESET_InLow,
    input  logic       SC_GAME_STATUS_StartGame_InLow,
    input  logic       SC_GAME_STATUS_LifesSignal_InLow,
    input  logic       SC_GAME_STATUS_NextLevel_InLow,
    input  logic       SC_GAME_STATUS_ClearLost_InLow,
    input  logic       SC_GAME_STATUS_TransitionStart_InLow,
    output logic       SC_GAME_STATUS_LifesCounterComparator_OutLow,
    output logic       SC_GAME_STATUS_LevelCounterComparator_OutLow,
    output logic       SC_GAME_STATUS_TransitionDone_OutLow,
    output logic       SC_GAME_STATUS_TransitionBusy_OutHigh,
    output logic [2:0] SC_GAME_STATUS_Lives_OutBUS,
    output logic [2:0] SC_GAME_STATUS_Level_OutBUS
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [24:0] cnt_q, cnt_d;
    logic [2:0]  lives_q, lives_d, level_q, level_d;
    logic        lifes_prev_q, next_prev_q, ts_prev_q, armed_q;
    logic        lifes_ev, next_ev, ts_ev;
    // armed_q masks the first cycle after reset so a line held low across release is not an edge
    assign lifes_ev = armed_q & lifes_prev_q & ~SC_GAME_STATUS_LifesSignal_InLow;
    assign next_ev  = armed_q & next_prev_q & ~SC_GAME_STATUS_NextLevel_InLow;
    assign ts_ev    = armed_q & ts_prev_q & ~SC_GAME_STATUS_TransitionStart_InLow;
    always_ff @(posedge SC_GAME_STATUS_CLOCK_50) begin
        if (!SC_GAME_STATUS_RESET_InLow) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lives_q      <= '0;
            level_q      <= '0;
            lifes_prev_q <= 1'b1;
            next_prev_q  <= 1'b1;
            ts_prev_q    <= 1'b1;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            lifes_prev_q <= SC_GAME_STATUS_LifesSignal_InLow;
            next_prev_q  <= SC_GAME_STATUS_NextLevel_InLow;
            ts_prev_q    <= SC_GAME_STATUS_TransitionStart_InLow;
            armed_q      <= 1'b1;
        end
    end
    always_comb begin
        lives_d = lives_q;
        level_d = level_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!SC_GAME_STATUS_StartGame_InLow) begin
            lives_d = 3'(INIT_LIVES);
            level_d = '0;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            if (!SC_GAME_STATUS_ClearLost_InLow) begin
                lives_d = 3'(INIT_LIVES);
            end else begin
                lives_d = (lifes_ev && lives_q != 3'd0) ? lives_q - 3'd1 : lives_q;
                level_d = (next_ev && level_q != 3'(MAX_LEVEL)) ? level_q + 3'd1 : level_q;
            end
            case (state_q)
                IDLE: begin
                    state_d = ts_ev ? RUN : IDLE;
                    cnt_d   = '0;
                end
                RUN: begin
                    state_d = (cnt_q == 25'(TRANSITION_TICKS - 1)) ? DONE : RUN;
                    cnt_d   = (cnt_q == 25'(TRANSITION_TICKS - 1)) ? '0 : cnt_q + 25'd1;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end
    assign SC_GAME_STATUS_LifesCounterComparator_OutLow = (lives_q != 3'd0);
    assign SC_GAME_STATUS_LevelCounterComparator_OutLow = (level_q != 3'(MAX_LEVEL));
    assign SC_GAME_STATUS_TransitionDone_OutLow         = (state_q != DONE);
    assign SC_GAME_STATUS_TransitionBusy_OutHigh        = (state_q == RUN);
    assign SC_GAME_STATUS_Lives_OutBUS                  = lives_q;
    assign SC_GAME_STATUS_Level_OutBUS                  = level_q;
endmodule

// File: tb/tb_sc_game_status.sv
// tb_sc_game_status: scoreboard bench comparing sc_game_status against a behavioural model every cycle
module tb_sc_game_status;
    localparam int IL = 3;
    localparam int ML = 4;
    localparam int TT = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0, start_n = 1'b1, lifes_n = 1'b1, next_n = 1'b1, clear_n = 1'b1, ts_n = 1'b1;
    logic lc_o, vc_o, done_n_o, busy_o;
    logic [2:0] lives_o, level_o;
    int n_chk = 0, n_pass = 0;
    typedef struct {int lives; int level; int lc; int vc; int dn; int bz;} exp_t;
    exp_t q[$];
    int m_lives = 0, m_level = 0, m_st = 0, m_cnt = 0;
    bit p_l = 1, p_n = 1, p_t = 1, m_arm = 0;
    always #5 clk = ~clk;
    sc_game_status #(.INIT_LIVES(IL), .MAX_LEVEL(ML), .TRANSITION_TICKS(TT)) dut (
        .SC_GAME_STATUS_CLOCK_50(clk),
        .SC_GAME_STATUS_RESET_InLow(rst_n),
        .SC_GAME_STATUS_StartGame_InLow(start_n),
        .SC_GAME_STATUS_LifesSignal_InLow(lifes_n),
        .SC_GAME_STATUS_NextLevel_InLow(next_n),
        .SC_GAME_STATUS_ClearLost_InLow(clear_n),
        .SC_GAME_STATUS_TransitionStart_InLow(ts_n),
        .SC_GAME_STATUS_LifesCounterComparator_OutLow(lc_o),
        .SC_GAME_STATUS_LevelCounterComparator_OutLow(vc_o),
        .SC_GAME_STATUS_TransitionDone_OutLow(done_n_o),
        .SC_GAME_STATUS_TransitionBusy_OutHigh(busy_o),
        .SC_GAME_STATUS_Lives_OutBUS(lives_o),
        .SC_GAME_STATUS_Level_OutBUS(level_o)
    );
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic step();
        exp_t e;
        bit el, en, et;
        if (!rst_n) begin
            m_lives = 0; m_level = 0; m_st = 0; m_cnt = 0;
            p_l = 1; p_n = 1; p_t = 1; m_arm = 0;
        end else begin
            el = m_arm && p_l && !lifes_n;
            en = m_arm && p_n && !next_n;
            et = m_arm && p_t && !ts_n;
            p_l = lifes_n; p_n = next_n; p_t = ts_n; m_arm = 1;
            if (!start_n) begin
                m_lives = IL; m_level = 0; m_st = 0; m_cnt = 0;
            end else begin
                if (!clear_n) m_lives = IL;
                else begin
                    if (el && m_lives > 0) m_lives--;
                    if (en && m_level < ML) m_level++;
                end
                case (m_st)
                    0: begin if (et) m_st = 1; m_cnt = 0; end
                    1: if (m_cnt == TT - 1) begin m_st = 2; m_cnt = 0; end else m_cnt++;
                    default: m_st = 0;
                endcase
            end
        end
        e = '{m_lives, m_level, int'(m_lives != 0), int'(m_level != ML), int'(m_st != 2), int'(m_st == 1)};
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("lives", int'(lives_o), e.lives);
        chk("level", int'(level_o), e.level);
        chk("lives_cmp", int'(lc_o), e.lc);
        chk("level_cmp", int'(vc_o), e.vc);
        chk("done_n", int'(done_n_o), e.dn);
        chk("busy", int'(busy_o), e.bz);
    endtask
    task automatic pulse_lifes();
        lifes_n = 0; repeat (3) step();
        lifes_n = 1; step();
    endtask
    task automatic pulse_next();
        next_n = 0; step();
        next_n = 1; step();
    endtask
    initial begin
        int k, lows;
        repeat (2) step();
        chk("rst_lives", int'(lives_o), 0);
        chk("rst_lives_cmp", int'(lc_o), 0);
        chk("rst_level_cmp", int'(vc_o), 1);
        chk("rst_done_n", int'(done_n_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        rst_n = 1; step();
        start_n = 0; step();
        start_n = 1;
        chk("start_lives", int'(lives_o), IL);
        chk("start_level", int'(level_o), 0);
        repeat (4) pulse_lifes();
        chk("lives_sat", int'(lives_o), 0);
        chk("lives_sat_cmp", int'(lc_o), 0);
        repeat (5) pulse_next();
        chk("level_sat", int'(level_o), ML);
        chk("level_sat_cmp", int'(vc_o), 0);
        clear_n = 0; step();
        clear_n = 1;
        chk("clear_lives", int'(lives_o), IL);
        chk("clear_level", int'(level_o), ML);
        ts_n = 0; step();
        chk("busy_start", int'(busy_o), 1);
        k = 0;
        do begin
            ts_n = (k == 3) ? 1'b0 : 1'b1;
            step();
            k++;
        end while (done_n_o && k < 40);
        chk("done_spacing", k, TT);
        step();
        chk("done_one_cycle", int'(done_n_o), 1);
        pulse_lifes(); pulse_lifes();
        chk("lives_one", int'(lives_o), 1);
        start_n = 0; lifes_n = 0; step();
        start_n = 1; lifes_n = 1;
        chk("prio_start_lives", int'(lives_o), IL);
        chk("prio_start_level", int'(level_o), 0);
        pulse_lifes();
        clear_n = 0; lifes_n = 0; step();
        clear_n = 1; lifes_n = 1;
        chk("prio_clear_lives", int'(lives_o), IL);
        step();
        ts_n = 0; step();
        ts_n = 1; repeat (5) step();
        rst_n = 0; next_n = 0; ts_n = 0; repeat (2) step();
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_done_n", int'(done_n_o), 1);
        chk("midrst_lives", int'(lives_o), 0);
        rst_n = 1;
        lows = 0;
        repeat (TT + 4) begin step(); lows += int'(!done_n_o); end
        chk("held_low_no_level", int'(level_o), 0);
        chk("held_low_no_busy", int'(busy_o), 0);
        chk("midrst_no_done", lows, 0);
        next_n = 1; ts_n = 1; step();
        ts_n = 0; step();
        ts_n = 1; repeat (3) step();
        start_n = 0; step();
        start_n = 1;
        lows = 0;
        repeat (TT + 4) begin step(); lows += int'(!done_n_o); end
        chk("abort_no_done", lows, 0);
        repeat (400) begin
            rst_n   = $urandom_range(0, 99) != 0;
            start_n = $urandom_range(0, 29) != 0;
            clear_n = $urandom_range(0, 19) != 0;
            lifes_n = $urandom_range(0, 2) != 0;
            next_n  = $urandom_range(0, 2) != 0;
            ts_n    = $urandom_range(0, 9) != 0;
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
